// File: rtl/nasti_stream_pkg.sv
// nasti_stream_pkg: shared widths, limits and arbiter state type for the stream arbiter
package nasti_stream_pkg;
    localparam int N_MASTER_MAX = 8;
    localparam int DATA_W       = 32;
    localparam int STRB_W       = DATA_W / 8;
    localparam int ID_W         = 4;
    localparam int DEST_W       = 4;
    localparam int USER_W       = 8;
    typedef enum logic {IDLE, LOCKED} arb_state_e;
endpackage

// File: rtl/nasti_stream_channel_if.sv
// nasti_stream_channel: one stream channel bundle with producer and consumer views
interface nasti_stream_channel;
    import nasti_stream_pkg::*;
    logic              t_valid;
    logic              t_ready;
    logic [DATA_W-1:0] t_data;
    logic [STRB_W-1:0] t_strb;
    logic [STRB_W-1:0] t_keep;
    logic              t_last;
    logic [ID_W-1:0]   t_id;
    logic [DEST_W-1:0] t_dest;
    logic [USER_W-1:0] t_user;
    modport master (output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user, input t_ready);
    modport slave (input t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user, output t_ready);
endinterface

// File: rtl/nasti_stream_rr_pick.sv
// nasti_stream_rr_pick: combinational round-robin pick of the first requester after the last owner
module nasti_stream_rr_pick #(
    parameter int N  = 2,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  pick,
    output logic          valid
);
    logic [N-1:0] above, hi;
    for (genvar i = 0; i < N; i++) begin : g_above
        assign above[i] = LW'(i) > last;
    end
    assign hi    = req & above;
    assign pick  = (|hi) ? (hi & -hi) : (req & -req);
    assign valid = |req;
endmodule

// File: rtl/nasti_stream_arbiter.sv
// nasti_stream_arbiter: packet-locked round-robin merge of N stream masters onto one slave stream
module nasti_stream_arbiter
    import nasti_stream_pkg::*;
#(
    parameter int N_MASTER  = 2,
    parameter int MAX_BEATS = 256
) (
    input  logic                aclk,
    input  logic                areset,
    nasti_stream_channel.slave  master [N_MASTER],
    nasti_stream_channel.master slave,
    output logic [N_MASTER-1:0] grant,
    output logic                overrun
);
    localparam int LW = $clog2(N_MASTER);
    localparam int CW = $clog2(MAX_BEATS + 1);
    arb_state_e          state, state_nxt;
    logic [LW-1:0]       owner, last_owner, pick_idx;
    logic [CW-1:0]       beats;
    logic [N_MASTER-1:0] m_valid, m_last, pick;
    logic [DATA_W-1:0]   m_data [N_MASTER];
    logic [STRB_W-1:0]   m_strb [N_MASTER];
    logic [STRB_W-1:0]   m_keep [N_MASTER];
    logic [ID_W-1:0]     m_id   [N_MASTER];
    logic [DEST_W-1:0]   m_dest [N_MASTER];
    logic [USER_W-1:0]   m_user [N_MASTER];
    logic                pick_valid, locked, accept, cut, eop;

    if (N_MASTER < 2 || N_MASTER > N_MASTER_MAX) begin : g_bad_n
        $error("nasti_stream_arbiter: N_MASTER out of range");
    end

    for (genvar i = 0; i < N_MASTER; i++) begin : g_master
        assign m_valid[i]        = master[i].t_valid;
        assign m_last[i]         = master[i].t_last;
        assign m_data[i]         = master[i].t_data;
        assign m_strb[i]         = master[i].t_strb;
        assign m_keep[i]         = master[i].t_keep;
        assign m_id[i]           = master[i].t_id;
        assign m_dest[i]         = master[i].t_dest;
        assign m_user[i]         = master[i].t_user;
        assign master[i].t_ready = grant[i] & slave.t_ready;
    end

    nasti_stream_rr_pick #(.N(N_MASTER), .LW(LW)) u_pick (
        .req   (m_valid),
        .last  (last_owner),
        .pick  (pick),
        .valid (pick_valid)
    );

    // the beat that reaches MAX_BEATS is forced to end the packet
    assign locked        = (state == LOCKED);
    assign cut           = (beats == CW'(MAX_BEATS - 1));
    assign eop           = m_last[owner] | cut;
    assign accept        = locked & m_valid[owner] & slave.t_ready;
    assign slave.t_valid = locked & m_valid[owner];
    assign slave.t_last  = locked & eop;
    assign slave.t_data  = locked ? m_data[owner] : '0;
    assign slave.t_strb  = locked ? m_strb[owner] : '0;
    assign slave.t_keep  = locked ? m_keep[owner] : '0;
    assign slave.t_id    = locked ? m_id[owner]   : '0;
    assign slave.t_dest  = locked ? m_dest[owner] : '0;
    assign slave.t_user  = locked ? m_user[owner] : '0;

    // encode the one-hot pick into the owner index
    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_MASTER; k++) pick_idx = pick[k] ? LW'(k) : pick_idx;
    end

    // lock on any request, release after the accepted end-of-packet beat
    always_comb begin
        state_nxt = state;
        state_nxt = locked ? ((accept & eop) ? IDLE : LOCKED) : (pick_valid ? LOCKED : IDLE);
    end

    // state, ownership, beat count and overrun pulse registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            last_owner <= LW'(N_MASTER - 1);
            beats      <= '0;
            overrun    <= 1'b0;
        end else begin
            state   <= state_nxt;
            overrun <= accept & cut & ~m_last[owner];
            if (!locked) begin
                grant <= pick;
                owner <= pick_idx;
                beats <= '0;
            end else if (accept) begin
                beats <= beats + CW'(1);
                if (eop) begin
                    grant      <= '0;
                    last_owner <= owner;
                end
            end
        end
    end
endmodule

// File: tb/tb_nasti_stream_arbiter.sv
// tb_nasti_stream_arbiter: directed and random checks of the stream arbiter against a packet-level model
module tb_nasti_stream_arbiter;
    import nasti_stream_pkg::*;
    localparam int N  = 4;
    localparam int MB = 4;

    logic              aclk = 1'b0;
    logic              areset;
    logic              sr;
    logic [N-1:0]      grant;
    logic              overrun;
    logic [N-1:0]      d_valid, d_last, d_ready, en;
    logic [DATA_W-1:0] d_data [N];

    logic [32:0]  q [N][$];
    logic [N-1:0] own_log [$];
    logic         vld_log [$];
    logic [32:0]  out_log [$];
    int m_owner = -1, m_last = N - 1, m_cnt = 0;
    bit m_ovr = 1'b0;
    int checks = 0, errors = 0, ovr_cnt = 0, rdy0_cnt = 0, pops = 0;
    int e25 [8] = '{0, 1, 1, 1, 0, 2, 2, 2};
    int e27 [8] = '{0, 1, 1, 1, 1, 0, 1, 1};
    int e30 [9] = '{0, 4, 4, 0, 4, 4, 0, 4, 4};

    always #5 aclk = ~aclk;

    nasti_stream_channel m_if [N] ();
    nasti_stream_channel s_if ();

    for (genvar i = 0; i < N; i++) begin : g_src
        assign m_if[i].t_valid = d_valid[i];
        assign m_if[i].t_last  = d_last[i];
        assign m_if[i].t_data  = d_data[i];
        assign m_if[i].t_strb  = d_data[i][3:0];
        assign m_if[i].t_keep  = d_data[i][7:4];
        assign m_if[i].t_id    = ID_W'(i);
        assign m_if[i].t_dest  = d_data[i][11:8];
        assign m_if[i].t_user  = d_data[i][31:24];
        assign d_ready[i]      = m_if[i].t_ready;
    end
    assign s_if.t_ready = sr;

    nasti_stream_arbiter #(.N_MASTER(N), .MAX_BEATS(MB)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .master  (m_if),
        .slave   (s_if),
        .grant   (grant),
        .overrun (overrun)
    );

    function automatic logic [55:0] fields(logic [31:0] d, int id);
        return {d, d[3:0], d[7:4], 4'(id), d[11:8], d[31:24]};
    endfunction

    function automatic bit busy();
        bit b = (m_owner >= 0);
        for (int i = 0; i < N; i++) b |= (q[i].size() != 0);
        return b;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(int m, int n, bit term);
        for (int b = 1; b <= n; b++) q[m].push_back({term && b == n, 32'($urandom)});
    endtask

    // one clock: drive sources, check outputs against the model, advance the model
    task automatic cycle();
        int o;
        bit found;
        logic [N-1:0] xr;
        for (int i = 0; i < N; i++) begin
            d_valid[i] = en[i] && q[i].size() > 0;
            if (d_valid[i]) begin
                d_data[i] = q[i][0][31:0];
                d_last[i] = q[i][0][32];
            end else begin
                d_data[i] = $urandom;
                d_last[i] = 1'($urandom);
            end
        end
        #1;
        o  = m_owner;
        xr = '0;
        if (o >= 0) xr[o] = sr;
        chk("grant", 64'(grant), o >= 0 ? 64'(1) << o : 64'(0));
        chk("t_ready", 64'(d_ready), 64'(xr));
        chk("t_valid", 64'(s_if.t_valid), 64'(o >= 0 && d_valid[o]));
        chk("t_last", 64'(s_if.t_last), 64'(o >= 0 && (d_last[o] || m_cnt == MB - 1)));
        chk("payload", 64'({s_if.t_data, s_if.t_strb, s_if.t_keep, s_if.t_id, s_if.t_dest, s_if.t_user}),
            o >= 0 ? 64'(fields(d_data[o], o)) : 64'(0));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        own_log.push_back(grant);
        vld_log.push_back(s_if.t_valid);
        if (overrun === 1'b1) ovr_cnt++;
        if (d_ready[0] === 1'b1) rdy0_cnt++;
        if (s_if.t_valid === 1'b1 && sr) out_log.push_back({s_if.t_last, s_if.t_data});
        if (areset) begin
            m_owner = -1;
            m_last  = N - 1;
            m_cnt   = 0;
            m_ovr   = 1'b0;
        end else begin
            m_ovr = 1'b0;
            if (o < 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && d_valid[(m_last + k) % N]) begin
                        found   = 1'b1;
                        m_owner = (m_last + k) % N;
                        m_cnt   = 0;
                    end
                end
            end else if (d_valid[o] && sr) begin
                void'(q[o].pop_front());
                pops++;
                m_cnt++;
                if (d_last[o] || m_cnt == MB) begin
                    m_ovr   = !d_last[o];
                    m_last  = o;
                    m_owner = -1;
                end
            end
        end
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic run(int maxc);
        int c = 0;
        while (busy() && c < maxc) begin
            cycle();
            c++;
        end
        chk("drain", 64'(busy()), 64'(0));
    endtask

    task automatic clear_logs();
        own_log.delete();
        vld_log.delete();
        out_log.delete();
        ovr_cnt  = 0;
        rdy0_cnt = 0;
        pops     = 0;
    endtask

    initial begin
        logic [32:0]  sent [$];
        logic [N-1:0] nz [$];
        areset  = 1'b1;
        sr      = 1'b0;
        en      = '1;
        d_valid = '0;
        d_last  = '0;
        for (int i = 0; i < N; i++) d_data[i] = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        cycle();
        // two masters, 3-beat packets from reset
        clear_logs();
        sr = 1'b1;
        load(0, 3, 1'b1);
        load(1, 3, 1'b1);
        run(40);
        chk("seq25_len", 64'(own_log.size()), 64'(8));
        for (int i = 0; i < 8; i++) chk("seq25", 64'(own_log[i]), 64'(e25[i]));
        // back-pressure toggling during a 4-beat packet from master 1
        clear_logs();
        load(1, 4, 1'b1);
        sent = q[1];
        for (int c = 0; c < 20 && busy(); c++) begin
            sr = c[0];
            cycle();
        end
        chk("drain26", 64'(busy()), 64'(0));
        sr = 1'b1;
        chk("beats26", 64'(out_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) chk("order26", 64'(out_log[i]), 64'(sent[i]));
        chk("ready0_26", 64'(rdy0_cnt), 64'(0));
        // 6 beats without t_last cut at MAX_BEATS
        clear_logs();
        load(0, 6, 1'b0);
        repeat (8) cycle();
        for (int i = 0; i < 8; i++) chk("seq27", 64'(own_log[i]), 64'(e27[i]));
        chk("beats27", 64'(out_log.size()), 64'(6));
        chk("cut27", 64'({out_log[2][32], out_log[3][32], out_log[4][32], out_log[5][32]}), 64'(4'b0100));
        load(0, 1, 1'b1);
        run(20);
        chk("ovr27", 64'(ovr_cnt), 64'(1));
        // reset on beat 2 of a 5-beat packet abandons it
        clear_logs();
        load(0, 5, 1'b1);
        cycle();
        cycle();
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        clear_logs();
        load(2, 2, 1'b1);
        load(0, 2, 1'b1);
        run(40);
        chk("rst_grant", 64'(own_log[0]), 64'(0));
        chk("rst_valid", 64'(vld_log[0]), 64'(0));
        chk("rst_first", 64'(own_log[1]), 64'(1));
        chk("rst_second", 64'(own_log[4]), 64'(4));
        // all four masters with continuous 1-beat packets
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        clear_logs();
        for (int p = 0; p < 2; p++) for (int i = 0; i < N; i++) load(i, 1, 1'b1);
        run(60);
        chk("len29", 64'(own_log.size()), 64'(16));
        foreach (own_log[i]) if (own_log[i] != 0) nz.push_back(own_log[i]);
        chk("nz29", 64'(nz.size()), 64'(8));
        for (int i = 0; i < 8; i++) chk("rot29", 64'(nz[i]), 64'(1) << (i % N));
        // single requester, three back-to-back packets
        clear_logs();
        for (int p = 0; p < 3; p++) load(2, 2, 1'b1);
        run(40);
        chk("len30", 64'(own_log.size()), 64'(9));
        for (int i = 0; i < 9; i++) chk("seq30", 64'(own_log[i]), 64'(e30[i]));
        // random traffic with back-pressure and withdrawn requests
        clear_logs();
        for (int c = 0; c < 1500; c++) begin
            sr = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                en[i] = ($urandom_range(4) != 0);
                if (q[i].size() == 0 && $urandom_range(3) == 0) load(i, $urandom_range(6, 1), $urandom_range(9) != 0);
            end
            cycle();
        end
        en = '1;
        sr = 1'b1;
        for (int i = 0; i < N; i++) load(i, 1, 1'b1);
        run(2000);
        chk("beats_rand", 64'(out_log.size()), 64'(pops));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nasti_stream_arbiter.md
NASTI_STREAM_ARBITER -- requirements
Module: nasti_stream_arbiter

Interface
REQ-001 SHALL have parameter N_MASTER, default 2, meaning number of requesting stream masters (2..8).
REQ-002 SHALL have parameter MAX_BEATS, default 256, meaning the beat limit per packet before a forced release.
REQ-003 SHALL have port aclk, input, width 1, meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port areset, input, width 1, meaning the reset; it is synchronous and active-high.
REQ-005 SHALL have port master[N_MASTER], nasti_stream_channel.slave, meaning the requesting streams.
REQ-006 SHALL have port slave, nasti_stream_channel (master side), meaning the single shared downstream stream.
REQ-007 SHALL have port grant, output, width N_MASTER, meaning the one-hot current owner, or 0 when idle.
REQ-008 SHALL have port overrun, output, width 1, meaning a one-cycle pulse when a packet is cut at MAX_BEATS.

Function
REQ-009 SHALL implement FSM states IDLE and LOCKED.
REQ-010 In IDLE, SHALL select the first master with t_valid=1 by round-robin, starting at index (last_owner+1) mod N_MASTER.
REQ-011 SHALL go IDLE->LOCKED in the cycle a request is seen: grant is registered and asserted from the next cycle; no data passes in the IDLE cycle (1-cycle arbitration latency).
REQ-012 In LOCKED, SHALL pass through the owner's t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user and t_valid to slave combinationally.
REQ-013 SHALL drive owner master.t_ready = slave.t_ready; every non-owner t_ready = 0; in IDLE every t_ready = 0 and slave.t_valid = 0.
REQ-014 SHALL count accepted beats (owner t_valid & slave.t_ready) in a beat counter sized clog2(MAX_BEATS+1), cleared on entering LOCKED.
REQ-015 SHALL go LOCKED->IDLE after the beat with t_last=1 is accepted, set last_owner=owner, and clear grant next cycle.
REQ-016 SHALL release the lock after accepting beat number MAX_BEATS if t_last was not seen, force slave.t_last=1 on that beat, and pulse overrun for exactly one cycle.
REQ-017 SHALL never change the owner while LOCKED, even if the owner drops t_valid mid-packet (stall, not release).
REQ-018 When only one master requests, SHALL grant it again after its packet regardless of round-robin pointer, with one idle cycle between packets.
REQ-019 SHALL ignore t_valid of masters that deassert before being granted; no beat is consumed from them.
REQ-020 A single-beat packet (t_last on beat 1) SHALL occupy exactly one LOCKED cycle when slave.t_ready=1.

Reset
REQ-021 While areset=1 at a rising edge, SHALL enter IDLE, clear grant, beat counter and overrun, and set last_owner=N_MASTER-1 so master[0] wins first.
REQ-022 All slave outputs and master t_ready SHALL read 0 in the cycle after reset; a packet interrupted by reset is abandoned, not resumed.

Structure
REQ-023 SHALL place the state enum (IDLE, LOCKED) and the N_MASTER upper limit constant in the shared package nasti_stream_pkg.
REQ-024 SHALL implement round-robin selection in sub-module nasti_stream_rr_pick (inputs req vector and last index; outputs one-hot pick and valid), purely combinational.

Verification
REQ-025 Verification SHALL cover: N_MASTER=2, both masters request 3-beat packets from reset -> master[0] packet, 1 idle cycle, master[1] packet; grant sequence 01, 00, 10.
REQ-026 Verification SHALL cover: slave.t_ready toggled 1,0,1,0 during a 4-beat packet from master[1] -> beats emitted in order, no beat duplicated or dropped, master[0] t_ready stays 0 throughout.
REQ-027 Verification SHALL cover: MAX_BEATS=4, master[0] sends 6 beats without t_last -> beat 4 carries slave.t_last=1, overrun pulses once, FSM returns to IDLE, and the remaining 2 beats go out as a new packet.
REQ-028 Verification SHALL cover: areset asserted on beat 2 of a 5-beat packet -> next cycle grant=0, slave.t_valid=0; after release master[0] is granted first.
REQ-029 Verification SHALL cover: N_MASTER=4, all masters requesting continuously with 1-beat packets -> grant rotates 0,1,2,3,0 with no starvation.
REQ-030 Verification SHALL cover: only master[2] requests, 3 consecutive packets -> granted three times, each separated by exactly one idle cycle.
